regfile_decoded: RTL and testbench



---
 rtl/regfile_pkg.sv | 11 +
 rtl/regfile_decoded_if.sv | 39 +++
 rtl/regfile_decoded_decoder_onehot.sv | 17 +
 rtl/regfile_decoded.sv | 69 ++++++
 tb/tb_regfile_decoded.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// Shared defaults and types for the general-purpose register file.
// Imported by the interface, decoder and register file.
package regfile_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;

  typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
  typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/regfile_decoded_if.sv
// Register file port bundle: one write port, two read ports,
// scoreboard clear/status and debug write select.
interface regfile_decoded_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  localparam int NREG = 2**ADDR_W;

  logic              we;
  logic [ADDR_W-1:0] wa;
  logic [DATA_W-1:0] wd;
  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic [DATA_W-1:0] rd1;
  logic [DATA_W-1:0] rd2;
  logic              clr_mask;
  logic [NREG-1:0]   written;
  logic [NREG-1:0]   wr_sel;

  modport master (
    output we, wa, wd,
    output ra1, ra2,
    output clr_mask,
    input  rd1, rd2,
    input  written, wr_sel
  );

  modport slave (
    input  we, wa, wd,
    input  ra1, ra2,
    input  clr_mask,
    output rd1, rd2,
    output written, wr_sel
  );

endinterface

// File: rtl/regfile_decoded_decoder_onehot.sv
// Parametrised ADDR_W to 2**ADDR_W one-hot decoder with enable.
// An unknown address with en=1 propagates X in simulation.
module decoder_onehot #(
  parameter int ADDR_W = 5,
  localparam int NOUT = 2**ADDR_W
) (
  input  logic              en,
  input  logic [ADDR_W-1:0] addr,
  output logic [NOUT-1:0]   sel
);

  localparam logic [NOUT-1:0] ONE = {{(NOUT-1){1'b0}}, 1'b1};

  // Shift a single one into place; all-zero when disabled.
  always_comb sel = en ? (ONE << addr) : '0;

endmodule

// File: rtl/regfile_decoded.sv
// MIPS GPR file: 1W/2R, hardwired zero reg, written scoreboard.
// Optional write-through bypass under macro REGFILE_BYPASS_EN.
module regfile_decoded
  import regfile_pkg::*;
#(
  parameter int DATA_W   = DATA_W_DEF,
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  regfile_decoded_if.slave  bus
);

  localparam int NREG = 2**ADDR_W;

  localparam logic [NREG-1:0] ZMASK =
    (ZERO_REG != 0) ? {{(NREG-1){1'b0}}, 1'b1} : '0;

  logic [NREG-1:0]   sel;
  logic [NREG-1:0]   wmask;
  logic [NREG-1:0]   written_q;
  logic [DATA_W-1:0] regs [NREG];

  decoder_onehot #(
    .ADDR_W (ADDR_W)
  ) u_dec (
    .en   (bus.we),
    .addr (bus.wa),
    .sel  (sel)
  );

  // Register 0 never loads and never marks written.
  assign wmask       = sel & ~ZMASK;
  assign bus.wr_sel  = sel;
  assign bus.written = written_q;

  // Register array: async clear, at most one load per edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++)
        regs[k] <= '0;
    end else begin
      for (int k = 0; k < NREG; k++)
        if (wmask[k]) regs[k] <= bus.wd;
    end
  end

  // Scoreboard: clear first, then the write sets its bit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      written_q <= '0;
    end else begin
      written_q <= (bus.clr_mask ? '0 : written_q) | wmask;
    end
  end

  // Combinational read ports; reg 0 holds 0 when hardwired.
  always_comb begin
    bus.rd1 = regs[bus.ra1];
    bus.rd2 = regs[bus.ra2];
`ifdef REGFILE_BYPASS_EN
    if (wmask[bus.ra1]) bus.rd1 = bus.wd;
    if (wmask[bus.ra2]) bus.rd2 = bus.wd;
`else
`endif
  end

endmodule

// File: tb/tb_regfile_decoded.sv
// Randomised self-checking bench for regfile_decoded.
// Reference model: plain arrays updated from the write rules.
module tb_regfile_decoded;

  logic clk = 1'b0;
  logic reset_n;
  int   checks = 0;
  int   errors = 0;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  always #5 clk = ~clk;

  regfile_decoded_if #(.DATA_W(32), .ADDR_W(5)) bus ();
  regfile_decoded_if #(.DATA_W(8),  .ADDR_W(3)) sbus ();

  regfile_decoded #(
    .DATA_W (32), .ADDR_W (5), .ZERO_REG (1)
  ) dut (
    .clk (clk), .reset_n (reset_n), .bus (bus)
  );

  regfile_decoded #(
    .DATA_W (8), .ADDR_W (3), .ZERO_REG (1)
  ) dut_s (
    .clk (clk), .reset_n (reset_n), .bus (sbus)
  );

  logic [31:0] mdl [32];
  logic [31:0] mwr;

  task automatic model_reset();
    for (int k = 0; k < 32; k++) mdl[k] = '0;
    mwr = '0;
  endtask

  function automatic logic [31:0] exp_rd(input logic [4:0] ra);
    if (BYP && bus.we && ra == bus.wa && ra != 0) return bus.wd;
    return mdl[ra];
  endfunction

  // Advance one edge, applying the rules to the model, then settle.
  task automatic step();
    @(posedge clk);
    if (!reset_n) begin
      model_reset();
    end else begin
      if (bus.clr_mask) mwr = '0;
      if (bus.we && bus.wa != 0) begin
        mdl[bus.wa] = bus.wd;
        mwr[bus.wa] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle();
    bus.we = 1'b0;
    bus.clr_mask = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    idle();
    bus.wa = '0; bus.wd = '0;
    bus.ra1 = 5'd0; bus.ra2 = 5'd31;
    step(); step();
    checks++;
    if (bus.rd1 !== 32'h0) begin
      errors++; $display("FAIL reset_rd1 got %h exp 0", bus.rd1);
    end
    checks++;
    if (bus.rd2 !== 32'h0) begin
      errors++; $display("FAIL reset_rd2 got %h exp 0", bus.rd2);
    end
    checks++;
    if (bus.written !== 32'h0) begin
      errors++; $display("FAIL reset_written got %h exp 0", bus.written);
    end
    checks++;
    if (bus.wr_sel !== 32'h0) begin
      errors++; $display("FAIL reset_wr_sel got %h exp 0", bus.wr_sel);
    end
    reset_n = 1'b1;
    bus.we = 1'b1; bus.wa = 5'd7; bus.wd = 32'hDEADBEEF;
    step();
    idle();
    bus.ra1 = 5'd7;
    #1;
    checks++;
    if (bus.rd1 !== 32'hDEADBEEF) begin
      errors++; $display("FAIL load7 got %h exp deadbeef", bus.rd1);
    end
    #2 reset_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin
      errors++; $display("FAIL async_rst_rd1 got %h exp 0", bus.rd1);
    end
    checks++;
    if (bus.written !== 32'h0) begin
      errors++; $display("FAIL async_rst_wr got %h exp 0", bus.written);
    end
    bus.we = 1'b1; bus.wa = 5'd9; bus.wd = 32'hCAFEF00D;
    step();
    reset_n = 1'b1;
    idle();
    bus.ra1 = 5'd9;
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin
      errors++; $display("FAIL rst_write_lost got %h exp 0", bus.rd1);
    end
  endtask

  task automatic test_write_read();
    bus.we = 1'b1; bus.wa = 5'd3; bus.wd = 32'h12345678;
    #1;
    checks++;
    if (bus.wr_sel !== 32'h8) begin
      errors++; $display("FAIL wr_sel3 got %h exp 8", bus.wr_sel);
    end
    step();
    idle();
    bus.ra1 = 5'd3; bus.ra2 = 5'd3;
    #1;
    checks++;
    if (bus.rd1 !== 32'h12345678) begin
      errors++; $display("FAIL wr_rd1 got %h exp 12345678", bus.rd1);
    end
    checks++;
    if (bus.rd2 !== 32'h12345678) begin
      errors++; $display("FAIL wr_rd2 got %h exp 12345678", bus.rd2);
    end
    checks++;
    if (bus.written !== 32'h8) begin
      errors++; $display("FAIL wr_written got %h exp 8", bus.written);
    end
  endtask

  task automatic test_zero_reg();
    bus.we = 1'b1; bus.wa = 5'd0; bus.wd = 32'hFFFFFFFF;
    bus.ra1 = 5'd0;
    #1;
    checks++;
    if (bus.wr_sel !== 32'h1) begin
      errors++; $display("FAIL zero_wr_sel got %h exp 1", bus.wr_sel);
    end
    checks++;
    if (bus.rd1 !== 32'h0) begin
      errors++; $display("FAIL zero_bypass got %h exp 0", bus.rd1);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'h0) begin
      errors++; $display("FAIL zero_rd1 got %h exp 0", bus.rd1);
    end
    checks++;
    if (bus.written[0] !== 1'b0) begin
      errors++; $display("FAIL zero_written got %b exp 0", bus.written[0]);
    end
  endtask

  task automatic test_bypass();
    logic [31:0] exp;
    bus.we = 1'b1; bus.wa = 5'd5; bus.wd = 32'hA;
    step();
    bus.wd = 32'hB; bus.ra1 = 5'd5; bus.ra2 = 5'd6;
    #1;
    exp = BYP ? 32'hB : 32'hA;
    checks++;
    if (bus.rd1 !== exp) begin
      errors++; $display("FAIL bypass_same got %h exp %h", bus.rd1, exp);
    end
    step();
    idle();
    #1;
    checks++;
    if (bus.rd1 !== 32'hB) begin
      errors++; $display("FAIL bypass_next got %h exp b", bus.rd1);
    end
  endtask

  task automatic test_clear_race();
    idle();
    bus.clr_mask = 1'b1;
    step();
    bus.clr_mask = 1'b0;
    bus.we = 1'b1; bus.wa = 5'd2; bus.wd = $urandom;
    step();
    bus.wa = 5'd5; bus.wd = $urandom;
    step();
    idle();
    #1;
    checks++;
    if (bus.written !== 32'h24) begin
      errors++; $display("FAIL clr_pre got %h exp 24", bus.written);
    end
    bus.we = 1'b1; bus.wa = 5'd2; bus.clr_mask = 1'b1;
    bus.wd = $urandom;
    step();
    idle();
    #1;
    checks++;
    if (bus.written !== 32'h4) begin
      errors++; $display("FAIL clr_race got %h exp 4", bus.written);
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, es;
    for (int i = 0; i < 400; i++) begin
      bus.we = 1'($urandom);
      bus.wa = 5'($urandom);
      bus.wd = $urandom;
      bus.ra1 = ($urandom_range(0, 3) == 0) ? bus.wa : 5'($urandom);
      bus.ra2 = 5'($urandom);
      bus.clr_mask = ($urandom_range(0, 15) == 0);
      #1;
      e1 = exp_rd(bus.ra1);
      e2 = exp_rd(bus.ra2);
      es = bus.we ? (32'h1 << bus.wa) : 32'h0;
      checks++;
      if (bus.rd1 !== e1) begin
        errors++; $display("FAIL rnd_rd1 i=%0d got %h exp %h", i, bus.rd1, e1);
      end
      checks++;
      if (bus.rd2 !== e2) begin
        errors++; $display("FAIL rnd_rd2 i=%0d got %h exp %h", i, bus.rd2, e2);
      end
      checks++;
      if (bus.wr_sel !== es) begin
        errors++; $display("FAIL rnd_sel i=%0d got %h exp %h", i, bus.wr_sel, es);
      end
      step();
      checks++;
      if (bus.written !== mwr) begin
        errors++; $display("FAIL rnd_wr i=%0d got %h exp %h", i, bus.written, mwr);
      end
    end
    idle();
  endtask

  task automatic test_small();
    logic [7:0] e;
    for (int k = 0; k < 8; k++) begin
      sbus.we = 1'b1; sbus.wa = 3'(k); sbus.wd = 8'(k + 1);
      #1;
      checks++;
      if (sbus.wr_sel !== (8'h1 << k)) begin
        errors++; $display("FAIL small_sel k=%0d got %h", k, sbus.wr_sel);
      end
      step();
    end
    sbus.we = 1'b0;
    for (int k = 0; k < 8; k++) begin
      sbus.ra1 = 3'(k); sbus.ra2 = 3'(7 - k);
      #1;
      e = (k == 0) ? 8'h0 : 8'(k + 1);
      checks++;
      if (sbus.rd1 !== e) begin
        errors++; $display("FAIL small_rd1 k=%0d got %h exp %h", k, sbus.rd1, e);
      end
      e = (k == 7) ? 8'h0 : 8'(8 - k);
      checks++;
      if (sbus.rd2 !== e) begin
        errors++; $display("FAIL small_rd2 k=%0d got %h exp %h", k, sbus.rd2, e);
      end
    end
    checks++;
    if (sbus.written !== 8'hFE) begin
      errors++; $display("FAIL small_written got %h exp fe", sbus.written);
    end
  endtask

  initial begin
    model_reset();
    sbus.we = 1'b0; sbus.wa = '0; sbus.wd = '0;
    sbus.ra1 = '0; sbus.ra2 = '0; sbus.clr_mask = 1'b0;
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_clear_race();
    test_random();
    test_small();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
